xlr8_pinarb: RTL and testbench

Arbitrates ownership of individual port pins among NREQ on-chip peripherals (XB requesters) that want to override the AVR port's direction and output value. It drives the per-pin override vectors (xb_ddoe/xb_ddov/xb_pvoe/xb_pvov) of one port mux instance. It grants disjoint pin sets using round-robin order and holds each grant until the requester releases it.

---
 rtl/xlr8_pinarb_pkg.sv | 19 +
 rtl/xlr8_rr_pick.sv | 32 +++
 rtl/xlr8_pinarb.sv | 136 +++++++++++++
 tb/tb_xlr8_pinarb.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/xlr8_pinarb_pkg.sv
// Shared types and constants for the port-pin arbiter.
// Requester states and round-robin pointer sizing.
package xlr8_pinarb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StOwn  = 2'd2
  } req_state_e;

  // The pointer is sized for the largest supported requester count.
  localparam int unsigned NReqMax = 8;
  localparam int unsigned RrPtrW  = $clog2(NReqMax);

  function automatic logic [RrPtrW-1:0] rr_next(input int unsigned idx, input int unsigned nreq);
    return RrPtrW'((idx + 1) % nreq);
  endfunction

endpackage

// File: rtl/xlr8_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr_i,
// wrapping around to index 0.
module xlr8_rr_pick
  import xlr8_pinarb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]   eligible_i,
  input  logic [RrPtrW-1:0] rr_ptr_i,
  output logic [NREQ-1:0]   pick_o,
  output logic              valid_o
);

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    // Upper segment [rr_ptr_i, NREQ) has priority over the wrapped segment.
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!valid_o && eligible_i[j] && (j >= 32'(rr_ptr_i))) begin
        pick_o[j] = 1'b1;
        valid_o   = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!valid_o && eligible_i[j]) begin
        pick_o[j] = 1'b1;
        valid_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xlr8_pinarb.sv
// Pin-ownership arbiter: grants disjoint pin sets of one port to XB requesters
// in round-robin order and drives the port mux override vectors.
module xlr8_pinarb
  import xlr8_pinarb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_mask,
  input  logic [NREQ*WIDTH-1:0] req_oe,
  input  logic [NREQ*WIDTH-1:0] req_ov,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      xb_ddoe,
  output logic [WIDTH-1:0]      xb_ddov,
  output logic [WIDTH-1:0]      xb_pvoe,
  output logic [WIDTH-1:0]      xb_pvov,
  output logic [WIDTH-1:0]      busy_pins
);

  req_state_e        state_q    [NREQ];
  req_state_e        state_d    [NREQ];
  logic [WIDTH-1:0]  own_mask_q [NREQ];
  logic [WIDTH-1:0]  own_mask_d [NREQ];
  logic [RrPtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  busy_q, busy_d;
  logic [WIDTH-1:0]  ddov_q, ddov_d;
  logic [WIDTH-1:0]  pvov_q, pvov_d;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   pick;
  logic              pick_valid;

  // Eligibility uses the registered busy vector, so a freed pin is only
  // re-grantable one cycle after its release.
  always_comb begin
    eligible = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      eligible[r] = (state_q[r] == StWait) && req[r] &&
                    ((req_mask[r*WIDTH +: WIDTH] & busy_q) == '0);
    end
  end

  xlr8_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .pick_o     (pick),
    .valid_o    (pick_valid)
  );

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int unsigned r = 0; r < NREQ; r++) begin
      state_d[r]    = state_q[r];
      own_mask_d[r] = own_mask_q[r];
      unique case (state_q[r])
        StIdle: begin
          if (req[r]) state_d[r] = StWait;
        end
        StWait: begin
          if (!req[r]) begin
            state_d[r] = StIdle;
          end else if (pick[r]) begin
            state_d[r]    = StOwn;
            own_mask_d[r] = req_mask[r*WIDTH +: WIDTH];
          end
        end
        StOwn: begin
          if (!req[r]) begin
            state_d[r]    = StIdle;
            own_mask_d[r] = '0;
          end
        end
        default: begin
          state_d[r]    = StIdle;
          own_mask_d[r] = '0;
        end
      endcase
      if (pick_valid && pick[r]) rr_ptr_d = rr_next(r, NREQ);
    end
  end

  // Output registers are computed from next-state so enables and values
  // appear together with gnt.
  always_comb begin
    busy_d = '0;
    ddov_d = '0;
    pvov_d = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (state_d[r] == StOwn) begin
        busy_d = busy_d | own_mask_d[r];
        ddov_d = ddov_d | (own_mask_d[r] & req_oe[r*WIDTH +: WIDTH]);
        pvov_d = pvov_d | (own_mask_d[r] & req_ov[r*WIDTH +: WIDTH]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        state_q[r]    <= StIdle;
        own_mask_q[r] <= '0;
      end
      rr_ptr_q <= '0;
      busy_q   <= '0;
      ddov_q   <= '0;
      pvov_q   <= '0;
    end else begin
      for (int unsigned r = 0; r < NREQ; r++) begin
        state_q[r]    <= state_d[r];
        own_mask_q[r] <= own_mask_d[r];
      end
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      ddov_q   <= ddov_d;
      pvov_q   <= pvov_d;
    end
  end

  always_comb begin
    gnt = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      gnt[r] = (state_q[r] == StOwn);
    end
  end

  assign xb_ddoe   = busy_q;
  assign xb_pvoe   = busy_q;
  assign busy_pins = busy_q;
  assign xb_ddov   = ddov_q;
  assign xb_pvov   = pvov_q;

endmodule

// File: tb/tb_xlr8_pinarb.sv
// Directed bench for xlr8_pinarb: per-cycle vector table plus hand-written sequences,
// with an ownership-disjointness check after every clock.
module tb_xlr8_pinarb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_mask, req_oe, req_ov;
  logic [3:0]  gnt;
  logic [7:0]  xb_ddoe, xb_ddov, xb_pvoe, xb_pvov, busy_pins;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [7:0]  own_m [4];
  logic [3:0]  gnt_prev = '0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] mask;
    logic [31:0] oe;
    logic [31:0] ov;
    logic [3:0]  gnt;
    logic [7:0]  en;
    logic [7:0]  dv;
    logic [7:0]  pv;
  } vec_t;

  vec_t vecs[$];

  xlr8_pinarb #(
    .WIDTH (8),
    .NREQ  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_mask  (req_mask),
    .req_oe    (req_oe),
    .req_ov    (req_ov),
    .gnt       (gnt),
    .xb_ddoe   (xb_ddoe),
    .xb_ddov   (xb_ddov),
    .xb_pvoe   (xb_pvoe),
    .xb_pvov   (xb_pvov),
    .busy_pins (busy_pins)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic [3:0] q, input logic [31:0] m,
                             input logic [31:0] oe, input logic [31:0] ov, input logic [3:0] g,
                             input logic [7:0] en, input logic [7:0] dv, input logic [7:0] pv);
    vec_t t;
    t.rst = r; t.req = q; t.mask = m; t.oe = oe; t.ov = ov;
    t.gnt = g; t.en = en; t.dv = dv; t.pv = pv;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Tracks each owner's latched mask from the grant edge and checks disjointness.
  task automatic track(input logic [31:0] m);
    logic [7:0] acc;
    logic       ok;
    for (int r = 0; r < 4; r++) begin
      if (!gnt[r]) own_m[r] = '0;
      else if (!gnt_prev[r]) own_m[r] = m[r*8 +: 8];
    end
    gnt_prev = gnt;
    acc = '0;
    ok  = 1'b1;
    for (int r = 0; r < 4; r++) begin
      if ((acc & own_m[r]) != 8'h00) ok = 1'b0;
      acc = acc | own_m[r];
    end
    if (acc !== busy_pins || xb_ddoe !== busy_pins || xb_pvoe !== busy_pins) ok = 1'b0;
    check("disjoint_owners", {63'b0, ok}, 64'd1);
  endtask

  task automatic apply(input logic r, input logic [3:0] q, input logic [31:0] m,
                       input logic [31:0] oe, input logic [31:0] ov);
    rst = r; req = q; req_mask = m; req_oe = oe; req_ov = ov;
    @(posedge clk);
    #1;
    track(m);
  endtask

  initial begin
    int n;
    for (int r = 0; r < 4; r++) own_m[r] = '0;
    rst = 1'b1; req = '0; req_mask = '0; req_oe = '0; req_ov = '0;
    @(posedge clk);
    #1;

    // Single requester; values masked by owned pins.
    vecs.push_back(v(1, 4'h0, 32'h0, 32'h0, 32'h0, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h1, 32'h0F, 32'h0F, 32'h05, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h1, 32'h0F, 32'h0F, 32'h05, 4'h1, 8'h0F, 8'h0F, 8'h05));
    vecs.push_back(v(0, 4'h1, 32'h0F, 32'h0F, 32'h0A, 4'h1, 8'h0F, 8'h0F, 8'h0A));
    vecs.push_back(v(0, 4'h1, 32'h0F, 32'h0F, 32'hF3, 4'h1, 8'h0F, 8'h0F, 8'h03));
    vecs.push_back(v(0, 4'h0, 32'h0F, 32'h0F, 32'hF3, 4'h0, 8'h00, 8'h00, 8'h00));
    // Conflict, release latency, then release + request on the same pins.
    vecs.push_back(v(1, 4'h0, 32'h0, 32'h0, 32'h0, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h1, 32'h180F, 32'h180F, 32'h1000, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h1, 32'h180F, 32'h180F, 32'h1000, 4'h1, 8'h0F, 8'h0F, 8'h00));
    vecs.push_back(v(0, 4'h3, 32'h180F, 32'h180F, 32'h1000, 4'h1, 8'h0F, 8'h0F, 8'h00));
    vecs.push_back(v(0, 4'h3, 32'h180F, 32'h180F, 32'h1000, 4'h1, 8'h0F, 8'h0F, 8'h00));
    vecs.push_back(v(0, 4'h2, 32'h180F, 32'h180F, 32'h1000, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h2, 32'h180F, 32'h180F, 32'h1000, 4'h2, 8'h18, 8'h18, 8'h10));
    vecs.push_back(v(0, 4'h1, 32'h1818, 32'h180F, 32'h1000, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h1, 32'h1818, 32'h180F, 32'h1000, 4'h1, 8'h18, 8'h08, 8'h00));
    // Four disjoint requesters at once.
    vecs.push_back(v(1, 4'h0, 32'h0, 32'h0, 32'h0, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'hF, 32'hC0300C03, 32'hFFFFFFFF, 32'h40100401, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'hF, 32'hC0300C03, 32'hFFFFFFFF, 32'h40100401, 4'h1, 8'h03, 8'h03, 8'h01));
    vecs.push_back(v(0, 4'hF, 32'hC0300C03, 32'hFFFFFFFF, 32'h40100401, 4'h3, 8'h0F, 8'h0F, 8'h05));
    vecs.push_back(v(0, 4'hF, 32'hC0300C03, 32'hFFFFFFFF, 32'h40100401, 4'h7, 8'h3F, 8'h3F, 8'h15));
    vecs.push_back(v(0, 4'hF, 32'hC0300C03, 32'hFFFFFFFF, 32'h40100401, 4'hF, 8'hFF, 8'hFF, 8'h55));
    // Fairness: r1 and r2 alternate on the full port.
    vecs.push_back(v(1, 4'h0, 32'h0, 32'h0, 32'h0, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h6, 32'h00FFFF00, 32'h00AA5500, 32'h0, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h6, 32'h00FFFF00, 32'h00AA5500, 32'h0, 4'h2, 8'hFF, 8'h55, 8'h00));
    vecs.push_back(v(0, 4'h4, 32'h00FFFF00, 32'h00AA5500, 32'h0, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h6, 32'h00FFFF00, 32'h00AA5500, 32'h0, 4'h4, 8'hFF, 8'hAA, 8'h00));
    vecs.push_back(v(0, 4'h2, 32'h00FFFF00, 32'h00AA5500, 32'h0, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h6, 32'h00FFFF00, 32'h00AA5500, 32'h0, 4'h2, 8'hFF, 8'h55, 8'h00));
    vecs.push_back(v(0, 4'h4, 32'h00FFFF00, 32'h00AA5500, 32'h0, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h6, 32'h00FFFF00, 32'h00AA5500, 32'h0, 4'h4, 8'hFF, 8'hAA, 8'h00));
    // Zero mask grant and pointer beating index order (r2 before r1).
    vecs.push_back(v(1, 4'h0, 32'h0, 32'h0, 32'h0, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h3, 32'h000000FF, 32'hFFFFFFFF, 32'h0, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h3, 32'h000000FF, 32'hFFFFFFFF, 32'h0, 4'h1, 8'hFF, 8'hFF, 8'h00));
    vecs.push_back(v(0, 4'h3, 32'h000000FF, 32'hFFFFFFFF, 32'h0, 4'h3, 8'hFF, 8'hFF, 8'h00));
    vecs.push_back(v(0, 4'h7, 32'h000100FF, 32'hFFFFFFFF, 32'h0, 4'h3, 8'hFF, 8'hFF, 8'h00));
    vecs.push_back(v(0, 4'h5, 32'h000100FF, 32'hFFFFFFFF, 32'h0, 4'h1, 8'hFF, 8'hFF, 8'h00));
    vecs.push_back(v(0, 4'h7, 32'h000102FF, 32'hFFFFFFFF, 32'h0, 4'h1, 8'hFF, 8'hFF, 8'h00));
    vecs.push_back(v(0, 4'h6, 32'h000102FF, 32'hFFFFFFFF, 32'h0, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h6, 32'h000102FF, 32'hFFFFFFFF, 32'h0, 4'h4, 8'h01, 8'h01, 8'h00));
    vecs.push_back(v(0, 4'h6, 32'h000102FF, 32'hFFFFFFFF, 32'h0, 4'h6, 8'h03, 8'h03, 8'h00));
    // Mask change while owned is ignored.
    vecs.push_back(v(1, 4'h0, 32'h0, 32'h0, 32'h0, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h1, 32'h00000001, 32'hFFFFFFFF, 32'hFF, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h1, 32'h00000001, 32'hFFFFFFFF, 32'hFF, 4'h1, 8'h01, 8'h01, 8'h01));
    vecs.push_back(v(0, 4'h3, 32'h000002FF, 32'hFFFFFFFF, 32'hFF, 4'h1, 8'h01, 8'h01, 8'h01));
    vecs.push_back(v(0, 4'h3, 32'h000002FF, 32'hFFFFFFFF, 32'hFF, 4'h3, 8'h03, 8'h03, 8'h01));
    // Reset while r0/r1 own; held requests re-arbitrate from pointer 0.
    vecs.push_back(v(1, 4'h3, 32'h00040201, 32'hFFFFFFFF, 32'hFF, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h7, 32'h00040201, 32'hFFFFFFFF, 32'hFF, 4'h0, 8'h00, 8'h00, 8'h00));
    vecs.push_back(v(0, 4'h7, 32'h00040201, 32'hFFFFFFFF, 32'hFF, 4'h1, 8'h01, 8'h01, 8'h01));
    vecs.push_back(v(0, 4'h7, 32'h00040201, 32'hFFFFFFFF, 32'hFF, 4'h3, 8'h03, 8'h03, 8'h01));
    vecs.push_back(v(0, 4'h7, 32'h00040201, 32'hFFFFFFFF, 32'hFF, 4'h7, 8'h07, 8'h07, 8'h01));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].req, vecs[i].mask, vecs[i].oe, vecs[i].ov);
      check($sformatf("vec%0d gnt/ddoe/pvoe/busy/ddov/pvov", i),
            {20'b0, gnt, xb_ddoe, xb_pvoe, busy_pins, xb_ddov, xb_pvov},
            {20'b0, vecs[i].gnt, vecs[i].en, vecs[i].en, vecs[i].en, vecs[i].dv, vecs[i].pv});
    end

    // Drop in WAIT: no grant and the pointer must stay at 1 (r1 beats r3).
    apply(1'b1, 4'h0, 32'h0, 32'h0, 32'h0);
    apply(1'b0, 4'h1, 32'h000000FF, 32'h0, 32'h0);
    apply(1'b0, 4'h1, 32'h000000FF, 32'h0, 32'h0);
    check("w_own", {60'b0, gnt}, 64'h1);
    apply(1'b0, 4'h5, 32'h00FF00FF, 32'h0, 32'h0);
    apply(1'b0, 4'h1, 32'h00FF00FF, 32'h0, 32'h0);
    check("w_drop_no_grant", {60'b0, gnt}, 64'h1);
    apply(1'b0, 4'h0, 32'h00FF00FF, 32'h0, 32'h0);
    check("w_release", {52'b0, gnt, busy_pins}, 64'h0);
    apply(1'b0, 4'hA, 32'h01000100, 32'h0, 32'h0);
    n = 0;
    while (gnt == 4'h0 && n < 8) begin
      apply(1'b0, 4'hA, 32'h01000100, 32'h0, 32'h0);
      n++;
    end
    check("w_first_grant", {60'b0, gnt}, 64'h2);
    check("w_grant_latency", 64'(n), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
